// File: rtl/cart_pkg.sv
// Shared types for the SCV cartridge RAM: backup-engine states and default geometry.
package cart_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SAVE_RD  = 3'd2,
        SAVE_OUT = 3'd3,
        FIN      = 3'd4
    } bk_state_t;

    localparam int CART_AW_DEFAULT = 13;

endpackage

// File: rtl/cart_bram_mem.sv
// Single-port synchronous RAM with a registered read port (1-cycle latency).
module cart_bram_mem #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          we_i,
    output logic [DW-1:0] rdata_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Array contents survive reset; only the output register is cleared.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cart_bram.sv
// Battery-backed cart RAM: mirrored CPU strobe port plus a byte-stream load/save engine.
module cart_bram
    import cart_pkg::*;
#(
    parameter int AW = CART_AW_DEFAULT,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] DI,
    output logic [DW-1:0] DO,
    input  logic          nCE,
    input  logic          nWE,
    input  logic          nOE,
    input  logic [AW-1:0] MIRROR_MASK,
    input  logic          WP,
    input  logic          BK_LOAD,
    input  logic          BK_SAVE,
    input  logic [DW-1:0] BK_DI,
    input  logic          BK_DI_VALID,
    output logic          BK_DI_READY,
    output logic [DW-1:0] BK_DO,
    output logic          BK_DO_VALID,
    input  logic          BK_DO_READY,
    output logic          BUSY,
    output logic          DONE,
    output logic          DIRTY
);

    bk_state_t     state_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          dirty_q;
    logic          di_rdy_q;
    logic          do_vld_q;

    logic          cpu_we;
    logic          eng_we;
    logic          cnt_last;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    assign cpu_we   = ~nCE & ~nWE & ~WP & ~busy_q;
    assign eng_we   = (state_q == LOAD) & BK_DI_VALID;
    assign cnt_last = (cnt_q == '1);

    // The engine owns the RAM port for the whole transfer; the CPU is locked out.
    always_comb begin
        mem_addr  = A & MIRROR_MASK;
        mem_wdata = DI;
        mem_we    = cpu_we;
        if (busy_q) begin
            mem_addr  = cnt_q;
            mem_wdata = BK_DI;
            mem_we    = eng_we;
        end
    end

    cart_bram_mem #(
        .AW (AW),
        .DW (DW)
    ) u_mem (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .we_i    (mem_we),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dirty_q  <= 1'b0;
            di_rdy_q <= 1'b0;
            do_vld_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cpu_we) begin
                dirty_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (BK_LOAD) begin
                        state_q  <= LOAD;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        di_rdy_q <= 1'b1;
                    end else if (BK_SAVE) begin
                        state_q <= SAVE_RD;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (BK_DI_VALID) begin
                        if (cnt_last) begin
                            state_q  <= FIN;
                            di_rdy_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            dirty_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + AW'(1);
                        end
                    end
                end
                SAVE_RD: begin
                    state_q  <= SAVE_OUT;
                    do_vld_q <= 1'b1;
                end
                SAVE_OUT: begin
                    if (BK_DO_READY) begin
                        do_vld_q <= 1'b0;
                        if (cnt_last) begin
                            state_q <= FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            dirty_q <= 1'b0;
                        end else begin
                            cnt_q   <= cnt_q + AW'(1);
                            state_q <= SAVE_RD;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    di_rdy_q <= 1'b0;
                    do_vld_q <= 1'b0;
                end
            endcase
        end
    end

    // RAM address is held at cnt throughout SAVE_OUT, so the read register stays stable.
    assign BK_DO       = (state_q == SAVE_OUT) ? mem_rdata : '0;
    assign DO          = (~nCE & ~nOE & ~busy_q) ? mem_rdata : '1;
    assign BK_DI_READY = di_rdy_q;
    assign BK_DO_VALID = do_vld_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign DIRTY       = dirty_q;

endmodule

// File: doc/cart_bram.md
Name: cart_bram

Overview:
- Parametrised battery-backed cartridge RAM for SCV carts.
- Provides a CPU-side async-style strobe port (nCE/nWE/nOE) with runtime address mirroring.
- Adds a byte-stream backup port, used by the HPS save-file logic, to load or dump the full RAM image.
- Sits on the cart bus beside the ROM; the backup port connects to the save/load sequencer.

Parameters:
AW, 13, RAM address width; depth = 2**AW bytes
DW, 8, data width

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
A  in  AW  CPU address
DI  in  DW  CPU write data
DO  out  DW  CPU read data
nCE  in  1  chip enable, active low
nWE  in  1  write enable, active low
nOE  in  1  output enable, active low
MIRROR_MASK  in  AW  ANDed with A; sets the mounted RAM size (e.g. 'h07FF = 2 KB mirrored)
WP  in  1  write-protect for CPU writes
BK_LOAD  in  1  pulse: start a stream-in of the full image
BK_SAVE  in  1  pulse: start a stream-out of the full image
BK_DI  in  DW  load stream data
BK_DI_VALID  in  1  load data valid
BK_DI_READY  out  1  engine accepts load data
BK_DO  out  DW  save stream data
BK_DO_VALID  out  1  save data valid
BK_DO_READY  in  1  consumer accepts save data
BUSY  out  1  transfer in progress
DONE  out  1  one-cycle pulse at transfer end
DIRTY  out  1  CPU has written since the last load/save

Behaviour:
Reset:
- State is IDLE.
- Address counter = 0.
- DO register, BK_DO = 0.
- BK_DO_VALID, BK_DI_READY, BUSY, DONE, DIRTY = 0.
- RAM contents are unaffected.
- RESET asserted mid-transfer aborts to IDLE; no DONE pulse is issued.

CPU port:
- Effective address is A & MIRROR_MASK.
- Read data is registered from the effective address every cycle (1-cycle latency, same as the previous cart RAM).
- DO = registered data when ~nCE & ~nOE; otherwise DO = all-ones.
- Write occurs on the CLK edge when ~nCE & ~nWE & ~WP & ~BUSY. Such a write also sets DIRTY.
- While BUSY, CPU writes are dropped and DO reads all-ones.

State machine:
- IDLE:
  - BK_LOAD goes to LOAD; otherwise BK_SAVE goes to SAVE_RD.
  - If both are asserted in the same cycle, LOAD wins.
  - Entering either state clears the counter and asserts BUSY.
- LOAD:
  - BK_DI_READY = 1.
  - Each cycle with BK_DI_VALID: mem[cnt] <= BK_DI, cnt++.
  - When the byte at cnt = 2**AW-1 is accepted, go to FIN.
- SAVE_RD: issue a RAM read at cnt, then go to SAVE_OUT.
- SAVE_OUT:
  - BK_DO = read data, BK_DO_VALID = 1.
  - BK_DO is held stable until BK_DO_READY.
  - On handshake: if cnt = 2**AW-1 go to FIN; otherwise cnt++ and go to SAVE_RD.
  - Throughput is 1 byte per 2 cycles minimum.
- FIN: DONE = 1 for one cycle, clear DIRTY, BUSY = 0, return to IDLE.
- BK_LOAD and BK_SAVE are ignored while BUSY.
- The counter is AW bits wide; FIN detection uses the all-ones compare, never counter wrap.
- MIRROR_MASK does not affect the backup port, which always covers the full 2**AW image.
- BK_DI_READY = 0 and BK_DO_VALID = 0 outside their respective states.

Decomposition:
- Package cart_pkg holds: the state enum type bk_state_t (IDLE, LOAD, SAVE_RD, SAVE_OUT, FIN) and the localparam for the default 8 KB AW.
- One sub-module, cart_bram_mem: a single-port synchronous RAM, 1-cycle read, write-first irrelevant. Its address/data/write-enable are muxed between the CPU and the engine by BUSY.

Test Plan:
- CPU write/read, AW=13, mask 'h1FFF: write 'h5A at 'h0123, then read → DO='h5A one cycle after nOE low; DIRTY=1; deselected DO='hFF.
- Mirroring, mask 'h07FF: write 'hA5 at 'h0010, read 'h0810 and 'h1810 → 'hA5. WP=1 then write 'h00 at 'h0010 → still 'hA5, DIRTY unchanged.
- Load with AW=4:
  - Stream 16 bytes 'h00..'h0F with VALID gaps every 3rd cycle → DONE pulses once after byte 'h0F.
  - CPU reads 0..15 return 'h00..'h0F; DIRTY=0.
  - A CPU write during LOAD is discarded.
- Save with AW=4 and random BK_DO_READY stalls:
  - Output sequence equals RAM contents in address order.
  - BK_DO holds stable while READY=0.
  - Exactly 16 handshakes, then DONE; DIRTY cleared.
- BK_LOAD and BK_SAVE in the same cycle → LOAD entered. A BK_SAVE pulse mid-LOAD → ignored.
- RESET after 5 load bytes → IDLE, BUSY=0, no DONE; the 5 bytes remain in RAM, later addresses unchanged.
